// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default line format
// used by the transmitter, receiver and baud generator.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      BREAK,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 so an idle-high
// line reads as idle straight out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], d};
      end
   end

   assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a single-word holding register and overrun flag.
// Even parity is received and checked when UART_RX_PARITY_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 os_tick,
   input  logic                 rx_pin,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_rx_state_e       state_reg, state_next;
   logic [TW-1:0]        tick_reg;
   logic [BW-1:0]        bit_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [1:0]           settle_reg;
   logic [DATA_BITS-1:0] data_reg;
   logic                 valid_reg, ferr_reg, ovr_reg;
   logic                 rxs, sample_due, frame_done, load, consume;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_pin),
      .q     (rxs)
   );

   // The synchronizer holds 1 through reset; ignore it until real line data has
   // flushed through, otherwise a line held low at release would look like a start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settle_reg <= 2'b00;
      end else begin
         settle_reg <= {settle_reg[0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= BREAK;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BREAK:  if (settle_reg[1] && rxs) state_next = IDLE;
         IDLE:   if (!rxs) state_next = START;
         START:  if (sample_due) state_next = rxs ? IDLE : DATA;
         DATA: begin
            if (sample_due && bit_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
         PARITY: if (sample_due) state_next = STOP;
         STOP:   if (sample_due) state_next = rxs ? IDLE : BREAK;
         default: state_next = BREAK;
      endcase
   end

   // START samples at the half-bit point; every later state samples a full bit on.
   always_comb begin
      rx_busy    = 1'b0;
      sample_due = 1'b0;
      case (state_reg)
         START: begin
            rx_busy    = 1'b1;
            sample_due = os_tick && (tick_reg == HALF_LAST);
         end
         DATA, PARITY, STOP: begin
            rx_busy    = 1'b1;
            sample_due = os_tick && (tick_reg == FULL_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         if (!rx_busy) begin
            tick_reg <= '0;
         end else if (os_tick) begin
            tick_reg <= sample_due ? '0 : tick_reg + TW'(1);
         end
         if (state_reg == START) begin
            bit_reg <= '0;
         end else if (state_reg == DATA && sample_due) begin
            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_reg   <= bit_reg + BW'(1);
         end
      end
   end

   assign frame_done = (state_reg == STOP) && sample_due;
   assign consume    = valid_reg && rx_ready;
   assign load       = frame_done && (!valid_reg || rx_ready);

   // A load in the same cycle as a consume keeps rx_valid high and leaves overrun alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
         ovr_reg   <= 1'b0;
      end else begin
         if (load) begin
            data_reg  <= shift_reg;
            ferr_reg  <= ~rxs;
            valid_reg <= 1'b1;
         end else if (consume) begin
            valid_reg <= 1'b0;
         end
         if (frame_done && !load) begin
            ovr_reg <= 1'b1;
         end else if (consume && !load) begin
            ovr_reg <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit_reg, perr_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_bit_reg <= 1'b0;
         perr_reg    <= 1'b0;
      end else begin
         if (state_reg == PARITY && sample_due) begin
            par_bit_reg <= rxs;
         end
         if (load) begin
            perr_reg <= par_bit_reg ^ (^shift_reg);
         end
      end
   end

   assign parity_err = perr_reg;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data   = data_reg;
   assign rx_valid  = valid_reg;
   assign frame_err = ferr_reg;
   assign overrun   = ovr_reg;

endmodule
